// File: rtl/team_01_pkg.sv
// team_01_pkg: shared state/op encodings and memory word-address width
package team_01_pkg;
    localparam int MEM_AW = 12;
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP} state_t;
    typedef enum logic [1:0] {FETCH, LOAD, STORE, RMW} op_t;
endpackage

// File: rtl/byte_merge.sv
// byte_merge: per-lane select between old and new word
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  sel,
    output logic [31:0] merged
);
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lane
            assign merged[8*k +: 8] = sel[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
    endgenerate
endmodule

// File: rtl/request_unit.sv
// request_unit: arbitrates fetch/data requests onto a single busy-handshake memory port
module request_unit
    import team_01_pkg::*;
(
    input  logic              clk,
    input  logic              RST,
    input  logic              i_req_i,
    input  logic [31:0]       i_adr_i,
    output logic [31:0]       i_dat_o,
    output logic              i_ack_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [31:0]       d_adr_i,
    input  logic [31:0]       d_dat_i,
    input  logic [3:0]        d_sel_i,
    output logic [31:0]       d_dat_o,
    output logic              d_ack_o,
    output logic              read_o,
    output logic              write_o,
    output logic [MEM_AW-1:0] adr_o,
    output logic [31:0]       ram_dat_o,
    output logic [3:0]        sel_o,
    input  logic [31:0]       ram_dat_i,
    input  logic              busy_i,
    output logic              stall_o
);
    state_t      state, state_n;
    op_t         op, grant_op;
    logic        grant, done, in_wait, seen_busy;
    logic [31:0] merged;
    logic        unused_bits;

    assign unused_bits = ^{i_adr_i[31:14], i_adr_i[1:0], d_adr_i[31:14], d_adr_i[1:0]};

    byte_merge u_merge (
        .old_word (ram_dat_i),
        .new_word (ram_dat_o),
        .sel      (sel_o),
        .merged   (merged)
    );

    // next-state, arbitration and strobe decode
    always_comb begin
        state_n  = state;
        grant    = 1'b0;
        grant_op = FETCH;
        in_wait  = (state == RD_WAIT) || (state == WR_WAIT);
        done     = in_wait && seen_busy && !busy_i;
        read_o   = state == RD_ISSUE;
        write_o  = state == WR_ISSUE;
        stall_o  = state != IDLE;
        i_ack_o  = (state == RESP) && (op == FETCH);
        d_ack_o  = (state == RESP) && (op != FETCH);
        case (state)
            IDLE: begin
                if (d_write_i) begin
                    grant    = 1'b1;
                    grant_op = (d_sel_i == 4'hF || d_sel_i == 4'h0) ? STORE : RMW;
                    state_n  = (d_sel_i == 4'h0) ? RESP : (d_sel_i == 4'hF) ? WR_ISSUE : RD_ISSUE;
                end else if (d_read_i || i_req_i) begin
                    grant    = 1'b1;
                    grant_op = d_read_i ? LOAD : FETCH;
                    state_n  = RD_ISSUE;
                end
            end
            RD_ISSUE: state_n = RD_WAIT;
            RD_WAIT:  state_n = done ? ((op == RMW) ? WR_ISSUE : RESP) : RD_WAIT;
            WR_ISSUE: state_n = WR_WAIT;
            WR_WAIT:  state_n = done ? RESP : WR_WAIT;
            RESP:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // state register, request latches, busy tracking and read capture
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= IDLE;
            op        <= FETCH;
            seen_busy <= 1'b0;
            adr_o     <= '0;
            ram_dat_o <= '0;
            sel_o     <= '0;
            i_dat_o   <= '0;
            d_dat_o   <= '0;
        end else begin
            state     <= state_n;
            seen_busy <= in_wait && !done && (seen_busy || busy_i);
            if (grant) begin
                op        <= grant_op;
                adr_o     <= (grant_op == FETCH) ? i_adr_i[13:2] : d_adr_i[13:2];
                ram_dat_o <= (grant_op == FETCH) ? 32'h0 : d_dat_i;
                sel_o     <= (grant_op == FETCH) ? 4'h0 : d_sel_i;
            end
            if (state == RD_WAIT && done) begin
                if (op == FETCH) i_dat_o <= ram_dat_i;
                if (op == LOAD) d_dat_o <= ram_dat_i;
                if (op == RMW) ram_dat_o <= merged;
            end
        end
    end
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed and random transactions against a word-array reference model
module tb_request_unit;
    logic        clk = 0;
    logic        RST = 1;
    logic        i_req_i = 0;
    logic [31:0] i_adr_i = 0;
    logic [31:0] i_dat_o;
    logic        i_ack_o;
    logic        d_read_i = 0;
    logic        d_write_i = 0;
    logic [31:0] d_adr_i = 0;
    logic [31:0] d_dat_i = 0;
    logic [3:0]  d_sel_i = 0;
    logic [31:0] d_dat_o;
    logic        d_ack_o;
    logic        read_o;
    logic        write_o;
    logic [11:0] adr_o;
    logic [31:0] ram_dat_o;
    logic [3:0]  sel_o;
    logic [31:0] ram_dat_i;
    logic        busy_i = 0;
    logic        stall_o;

    logic [31:0] mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    int checks = 0;
    int failures = 0;
    int n_rd = 0, n_wr = 0, n_iack = 0, n_dack = 0, n_both = 0;
    logic [11:0] last_adr = 0;

    request_unit dut (
        .clk(clk), .RST(RST),
        .i_req_i(i_req_i), .i_adr_i(i_adr_i), .i_dat_o(i_dat_o), .i_ack_o(i_ack_o),
        .d_read_i(d_read_i), .d_write_i(d_write_i), .d_adr_i(d_adr_i), .d_dat_i(d_dat_i),
        .d_sel_i(d_sel_i), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
        .read_o(read_o), .write_o(write_o), .adr_o(adr_o), .ram_dat_o(ram_dat_o),
        .sel_o(sel_o), .ram_dat_i(ram_dat_i), .busy_i(busy_i), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    assign ram_dat_i = mem[adr_o];

    // memory: accept strobe, then hold busy for 2..4 cycles
    initial begin
        int left;
        left = 0;
        for (int i = 0; i < 4096; i++) mem[i] = i * 32'h9E3779B9 ^ 32'h5A5A1234;
        forever begin
            @(negedge clk);
            if (read_o || write_o) begin
                if (write_o) mem[adr_o] = ram_dat_o;
                busy_i = 1;
                left = $urandom_range(2, 4);
            end else if (left > 0) begin
                left--;
                if (left == 0) busy_i = 0;
            end
        end
    end

    // strobe and ack counters
    always @(negedge clk) begin
        if (read_o) begin n_rd++; last_adr = adr_o; end
        if (write_o) begin n_wr++; last_adr = adr_o; end
        if (i_ack_o) n_iack++;
        if (d_ack_o) n_dack++;
        if (i_ack_o && d_ack_o) n_both++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output bit got, output int cyc);
        got = 0;
        cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (i_ack_o || d_ack_o) begin got = 1; cyc = c; break; end
        end
    endtask

    // kind: 0 fetch, 1 load, 2 store
    task automatic xact(input string tag, input int kind, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] sel);
        int rd0, wr0, ia0, da0, erd, ewr, cyc;
        bit got;
        logic [11:0] w;
        rd0 = n_rd; wr0 = n_wr; ia0 = n_iack; da0 = n_dack;
        w = a[13:2];
        erd = (kind < 2 || (sel != 4'h0 && sel != 4'hF)) ? 1 : 0;
        ewr = (kind == 2 && sel != 4'h0) ? 1 : 0;
        if (kind == 2)
            for (int k = 0; k < 4; k++)
                if (sel[k]) ref_mem[w][8*k +: 8] = dat[8*k +: 8];
        if (kind == 0) begin i_req_i = 1; i_adr_i = a; end
        else if (kind == 1) begin d_read_i = 1; d_adr_i = a; end
        else begin d_write_i = 1; d_adr_i = a; d_dat_i = dat; d_sel_i = sel; end
        wait_ack(got, cyc);
        check({tag, "_ack_seen"}, got, 1);
        if (kind == 0) begin
            check({tag, "_iack"}, {i_ack_o, d_ack_o}, 2'b10);
            check({tag, "_idat"}, i_dat_o, ref_mem[w]);
        end else begin
            check({tag, "_dack"}, {i_ack_o, d_ack_o}, 2'b01);
            if (kind == 1) check({tag, "_ddat"}, d_dat_o, ref_mem[w]);
            if (kind == 2 && sel == 4'h0) check({tag, "_sel0_lat"}, cyc <= 2, 1);
        end
        i_req_i = 0; d_read_i = 0; d_write_i = 0;
        @(posedge clk); #1;
        check({tag, "_idle"}, stall_o, 0);
        check({tag, "_reads"}, n_rd - rd0, erd);
        check({tag, "_writes"}, n_wr - wr0, ewr);
        check({tag, "_acks"}, (n_iack - ia0) + (n_dack - da0), 1);
        if (erd + ewr > 0) check({tag, "_adr"}, last_adr, w);
        check({tag, "_mem"}, mem[w], ref_mem[w]);
    endtask

    initial begin
        int rd0, da0, ia0, cyc, kind;
        bit got;
        logic [31:0] a, dat;
        logic [3:0] sel;
        for (int i = 0; i < 4096; i++) ref_mem[i] = i * 32'h9E3779B9 ^ 32'h5A5A1234;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {stall_o, read_o, write_o, i_ack_o, d_ack_o, adr_o, ram_dat_o, sel_o, i_dat_o, d_dat_o}, 0);
        RST = 0;

        xact("prep_w4", 2, 32'h0000_0010, 32'hCAFEF00D, 4'hF);
        xact("load_w4", 1, 32'h0000_0010, 0, 0);
        check("load_w4_value", d_dat_o, 32'hCAFEF00D);
        xact("store_w8", 2, 32'h0000_0020, 32'h12345678, 4'hF);
        check("store_w8_value", mem[8], 32'h12345678);
        xact("prep_w8", 2, 32'h0000_0020, 32'h11223344, 4'hF);
        xact("rmw_w8", 2, 32'h0000_0020, 32'h0000AB00, 4'b0010);
        check("rmw_w8_value", mem[8], 32'h1122AB44);
        xact("store_sel0", 2, 32'h0000_0024, 32'hFFFFFFFF, 4'h0);
        xact("fetch_hi", 1, 32'hFFFF_C01B, 0, 0);
        xact("fetch_w3", 0, 32'h0000_000F, 0, 0);

        ia0 = n_iack; da0 = n_dack;
        i_req_i = 1; i_adr_i = 32'h0000_0040;
        d_read_i = 1; d_adr_i = 32'h0000_0010;
        wait_ack(got, cyc);
        check("arb_first_seen", got, 1);
        check("arb_first_is_data", {i_ack_o, d_ack_o}, 2'b01);
        check("arb_first_data", d_dat_o, ref_mem[4]);
        d_read_i = 0;
        wait_ack(got, cyc);
        check("arb_second_seen", got, 1);
        check("arb_second_is_fetch", {i_ack_o, d_ack_o}, 2'b10);
        check("arb_second_data", i_dat_o, ref_mem[16]);
        i_req_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check("arb_iacks", n_iack - ia0, 1);
        check("arb_dacks", n_dack - da0, 1);

        rd0 = n_rd; da0 = n_dack;
        d_read_i = 1; d_adr_i = 32'h0000_0030;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (read_o) begin got = 1; break; end
        end
        check("rst_saw_read", got, 1);
        @(posedge clk); #1;
        RST = 1; d_read_i = 0;
        @(posedge clk); #1;
        RST = 0;
        check("rst_mid_outputs", {stall_o, read_o, write_o, i_ack_o, d_ack_o, adr_o, ram_dat_o, sel_o, i_dat_o, d_dat_o}, 0);
        repeat (6) @(posedge clk);
        #1;
        check("rst_mid_no_ack", n_dack - da0, 0);
        check("rst_mid_one_read", n_rd - rd0, 1);
        xact("fetch_after_rst", 0, 32'h0000_0044, 0, 0);

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 3);
            if (kind == 3) kind = 2;
            a = {$urandom_range(0, 32'h3FFFF), 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            dat = $urandom;
            case ($urandom_range(0, 3))
                0: sel = 4'hF;
                1: sel = 4'h0;
                default: sel = 4'($urandom_range(1, 14));
            endcase
            xact("rand", kind, a, dat, sel);
        end

        check("never_both_acks", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 i_req_i  in  1  instruction fetch request, level, held until i_ack_o.
REQ-005 i_adr_i  in  32  fetch byte address.
REQ-006 i_dat_o  out  32  fetched word, valid while i_ack_o=1.
REQ-007 i_ack_o  out  1  one-cycle fetch completion pulse.
REQ-008 d_read_i / d_write_i  in  1 each  data load / store request, level, held until d_ack_o.
REQ-009 d_adr_i  in  32  data byte address.
REQ-010 d_dat_i  in  32  store data, byte lanes aligned to the word.
REQ-011 d_sel_i  in  4  store byte enables; bit k enables bits [8k+7:8k].
REQ-012 d_dat_o  out  32  loaded word, valid while d_ack_o=1.
REQ-013 d_ack_o  out  1  one-cycle data completion pulse.
REQ-014 read_o / write_o  out  1 each  memory read / write request strobes.
REQ-015 adr_o  out  12  memory word address.
REQ-016 ram_dat_o  out  32  memory write data.
REQ-017 sel_o  out  4  byte enables, forwarded for information only.
REQ-018 ram_dat_i  in  32  memory read data.
REQ-019 busy_i  in  1  memory busy.
REQ-020 stall_o  out  1  high whenever state is not IDLE.

Function
REQ-021 States SHALL be IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP.
REQ-022 In IDLE, arbitration SHALL grant data over instruction; if both d_write_i and d_read_i are high, the write SHALL win.
REQ-023 On grant, the block SHALL latch address, data, sel and op (FETCH, LOAD, STORE, RMW) and drive adr_o = addr[13:2]; addr[31:14] and addr[1:0] SHALL be ignored.
REQ-024 FETCH/LOAD: IDLE -> RD_ISSUE -> RD_WAIT -> RESP -> IDLE.
REQ-025 STORE with sel=4'hF: IDLE -> WR_ISSUE -> WR_WAIT -> RESP -> IDLE.
REQ-026 RMW (sel neither 0 nor 4'hF): IDLE -> RD_ISSUE -> RD_WAIT -> WR_ISSUE -> WR_WAIT -> RESP -> IDLE.
REQ-027 RMW merge: each byte lane SHALL take d_dat_i where sel is 1, and the read word where sel is 0.
REQ-028 STORE with sel=0 SHALL go IDLE -> RESP with no memory access.
REQ-029 read_o SHALL be 1 only in RD_ISSUE, and write_o only in WR_ISSUE, each for exactly one cycle.
REQ-030 adr_o and ram_dat_o SHALL stay constant from ISSUE through the end of WAIT.
REQ-031 Each WAIT state SHALL set a seen_busy flag when busy_i=1, and SHALL complete on the first cycle with seen_busy=1 and busy_i=0.
REQ-032 On RD_WAIT completion, ram_dat_i SHALL be captured into the response or merge register on that same edge.
REQ-033 RESP SHALL last exactly one cycle, with the ack of the granted port high and its data output valid; the non-granted ack SHALL remain 0.
REQ-034 The requester SHALL drop its request by the edge ending RESP; the next grant SHALL occur no earlier than the IDLE cycle after RESP.
REQ-035 i_dat_o and d_dat_o SHALL hold their last value outside RESP.

Reset
REQ-036 RST SHALL force IDLE and clear seen_busy, all latches, and every output to 0, from any state including mid-transaction.
REQ-037 The first cycle after RST deasserts SHALL be IDLE and eligible for grant.

Structure
REQ-038 The state enum, op enum and memory-address width constant (12) SHALL live in shared package team_01_pkg.
REQ-039 Byte-lane merging SHALL be a single sub-module, byte_merge, that is purely combinational: old word, new word and sel in; merged word out.

Verification
REQ-040 Load, d_adr_i=0x0000_0010, memory[4]=0xCAFEF00D -> adr_o=4, read_o pulses once, d_ack_o=1 with d_dat_o=0xCAFEF00D.
REQ-041 Store sel=4'hF, d_adr_i=0x20, d_dat_i=0x12345678 -> write_o pulses once, adr_o=8, memory[8]=0x12345678, one d_ack_o.
REQ-042 RMW sel=4'b0010, d_dat_i=0x0000AB00, memory[8]=0x11223344 -> one read then one write; memory[8]=0x1122AB44.
REQ-043 i_req_i and d_read_i raised in the same cycle -> data completes first; the fetch completes next, with no lost or duplicate acks.
REQ-044 RST asserted during RD_WAIT -> next cycle IDLE, all outputs 0, no ack; a subsequent fetch completes normally.
REQ-045 Store sel=0 -> d_ack_o within 2 cycles, write_o never asserted.
